hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the ID-stage hazard detector for the 5-stage RISC-V pipeline. It keeps a per-register scoreboard of cycles-until-forwardable. This supports variable-latency producers (ALU, load, multi-cycle MUL/DIV) and early-resolving consumers (branch compare and jalr in ID). It drives PC/IF-ID write enables and the ID/EX bubble, and honours a global pipeline hold.

---
 rtl/hsu_pkg.sv | 26 ++
 rtl/hsu_sb_entry.sv | 27 ++
 rtl/hazard_scoreboard_unit.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsu_pkg.sv
// Shared definitions for the hazard scoreboard unit: producer latencies,
// stall-cause codes and the per-cycle operating mode.
package hsu_pkg;

  localparam int MAX_LAT  = 7;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = MAX_LAT;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_RAW   = 2'd1,
    CAUSE_EARLY = 2'd2,
    CAUSE_WAW   = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_HOLD,
    MODE_FLUSH,
    MODE_STALL,
    MODE_ISSUE
  } mode_e;

endpackage

// File: rtl/hsu_sb_entry.sv
// One scoreboard slot: cycles until its register becomes forwardable.
// Saturating down-counter with load, freeze and synchronous active-low reset.
module hsu_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (freeze) begin
      cnt <= cnt;
    end else if (load) begin
      // a fresh issue to this register overrides its own decrement
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard scoreboard for the 5-stage pipeline with variable-latency
// producers. Optional performance counters are enabled by HSU_PERF_EN.
module hazard_scoreboard_unit
  import hsu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5,
  parameter int MAX_LAT  = 7,
  parameter int LAT_W    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            id_early,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic            id_flush,
  input  logic            hold,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            idex_bubble,
  output logic [1:0]      stall_cause
`ifdef HSU_PERF_EN
  ,
  output logic [31:0]     perf_raw,
  output logic [31:0]     perf_early,
  output logic [31:0]     perf_waw
`endif
);

  // Handshake: ID offers an instruction with id_valid; it is accepted (issued)
  // on a rising edge only when mode is MODE_ISSUE, otherwise it stays in ID.
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] lat_eff;
  logic             rs1_hit, rs2_hit;
  logic             raw_t, early_t, waw_t, stall;
  logic             issue_wr;
  cause_e           cause;
  mode_e            mode;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hsu_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .freeze   (hold),
      .load     (issue_wr && (id_rd == RA_W'(r))),
      .load_val (lat_eff),
      .cnt      (cnt[r])
    );
  end

  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0) lat_eff = LAT_W'(1);
    else if (int'(id_lat) > MAX_LAT) lat_eff = LAT_W'(MAX_LAT);
  end

  assign rs1_hit = id_rs1_used && (id_rs1 != '0);
  assign rs2_hit = id_rs2_used && (id_rs2 != '0);

  assign raw_t   = (rs1_hit && (cnt[id_rs1] > LAT_W'(1))) ||
                   (rs2_hit && (cnt[id_rs2] > LAT_W'(1)));
  assign early_t = id_early && ((rs1_hit && (cnt[id_rs1] != '0)) ||
                                (rs2_hit && (cnt[id_rs2] != '0)));
  // WAW keeps writebacks in order: a shorter producer waits out a longer one
  assign waw_t   = id_regwr && (id_rd != '0) && (cnt[id_rd] > lat_eff);

  always_comb begin
    cause = CAUSE_NONE;
    if (early_t)    cause = CAUSE_EARLY;
    else if (raw_t) cause = CAUSE_RAW;
    else if (waw_t) cause = CAUSE_WAW;
  end

  assign stall = id_valid && !id_flush && (cause != CAUSE_NONE);

  always_comb begin
    mode = MODE_ISSUE;
    if (!rst_n)        mode = MODE_RESET;
    else if (hold)     mode = MODE_HOLD;
    else if (id_flush) mode = MODE_FLUSH;
    else if (stall)    mode = MODE_STALL;
  end

  assign issue_wr = (mode == MODE_ISSUE) && id_valid && id_regwr && (id_rd != '0);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    stall_cause = CAUSE_NONE;
    case (mode)
      MODE_HOLD: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      MODE_FLUSH: idex_bubble = 1'b1;
      MODE_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        stall_cause = cause;
      end
      default: ;
    endcase
  end

`ifdef HSU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_raw   <= '0;
      perf_early <= '0;
      perf_waw   <= '0;
    end else if (mode == MODE_STALL) begin
      case (cause)
        CAUSE_RAW:   perf_raw   <= perf_raw + 32'd1;
        CAUSE_EARLY: perf_early <= perf_early + 32'd1;
        CAUSE_WAW:   perf_waw   <= perf_waw + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed pipeline scenarios
// with literal stall counts, then randomized traffic against a register model.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_early = 1'b0;
  logic       id_regwr = 1'b0, id_flush = 1'b0, hold = 1'b0;
  logic [2:0] id_lat = '0;
  logic       pc_write, ifid_write, idex_bubble;
  logic [1:0] stall_cause;
`ifdef HSU_PERF_EN
  logic [31:0] perf_raw, perf_early, perf_waw;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mcnt [32];
  int m_raw = 0, m_early = 0, m_waw = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_early    (id_early),
    .id_rd       (id_rd),
    .id_regwr    (id_regwr),
    .id_lat      (id_lat),
    .id_flush    (id_flush),
    .hold        (hold),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .stall_cause (stall_cause)
`ifdef HSU_PERF_EN
    ,
    .perf_raw    (perf_raw),
    .perf_early  (perf_early),
    .perf_waw    (perf_waw)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int eff_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > 7) return 7;
    return lat;
  endfunction

  function automatic int model_cause();
    bit r1, r2;
    r1 = id_rs1_used && id_rs1 != 0;
    r2 = id_rs2_used && id_rs2 != 0;
    if (id_early && ((r1 && mcnt[id_rs1] > 0) || (r2 && mcnt[id_rs2] > 0))) return 2;
    if ((r1 && mcnt[id_rs1] > 1) || (r2 && mcnt[id_rs2] > 1)) return 1;
    if (id_regwr && id_rd != 0 && mcnt[id_rd] > eff_lat(int'(id_lat))) return 3;
    return 0;
  endfunction

  function automatic bit model_stall();
    return id_valid && !id_flush && model_cause() != 0;
  endfunction

  initial for (int r = 0; r < 32; r++) mcnt[r] = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      m_raw = 0; m_early = 0; m_waw = 0;
    end else if (!hold) begin
      bit st;
      int c;
      st = model_stall();
      c  = model_cause();
      if (st) begin
        if (c == 1) m_raw++;
        if (c == 2) m_early++;
        if (c == 3) m_waw++;
      end
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      if (id_valid && !id_flush && !st && id_regwr && id_rd != 0)
        mcnt[id_rd] = eff_lat(int'(id_lat));
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin
    int e_pc, e_bub, e_cause;
    e_pc = 1; e_bub = 0; e_cause = 0;
    if (!rst_n) begin
      e_pc = 1;
    end else if (hold) begin
      e_pc = 0;
    end else if (id_flush) begin
      e_bub = 1;
    end else if (model_stall()) begin
      e_pc = 0; e_bub = 1; e_cause = model_cause();
    end
    check("pc_write", int'(pc_write), e_pc);
    check("ifid_write", int'(ifid_write), e_pc);
    check("idex_bubble", int'(idex_bubble), e_bub);
    check("stall_cause", int'(stall_cause), e_cause);
`ifdef HSU_PERF_EN
    check("perf_raw", int'(perf_raw), m_raw);
    check("perf_early", int'(perf_early), m_early);
    check("perf_waw", int'(perf_waw), m_waw);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_early = 1'b0; id_regwr = 1'b0; id_flush = 1'b0; hold = 1'b0;
  endtask

  task automatic set_instr(input int rs1, input bit use1, input int rs2, input bit use2,
                           input bit early, input int rd, input bit wr, input int lat);
    id_valid = 1'b1;
    id_rs1 = 5'(rs1); id_rs1_used = use1;
    id_rs2 = 5'(rs2); id_rs2_used = use2;
    id_early = early;
    id_rd = 5'(rd); id_regwr = wr; id_lat = 3'(lat);
    id_flush = 1'b0; hold = 1'b0;
  endtask

  // holds the current instruction in ID until it issues; reports stall cycles
  task automatic run_until_issue(output int stalls, output int first_cause);
    bit done;
    done = 1'b0; stalls = 0; first_cause = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (pc_write && !idex_bubble) done = 1'b1;
      else begin
        if (stalls == 0) first_cause = int'(stall_cause);
        stalls++;
      end
      next_cycle();
    end
    if (!done) check("issue_timeout", 0, 1);
    idle();
  endtask

  task automatic issue_instr(input int rs1, input bit use1, input int rs2, input bit use2,
                             input bit early, input int rd, input bit wr, input int lat,
                             input string name, input int exp_stalls, input int exp_cause);
    int s, c;
    set_instr(rs1, use1, rs2, use2, early, rd, wr, lat);
    run_until_issue(s, c);
    check({name, "_stalls"}, s, exp_stalls);
    if (exp_stalls > 0) check({name, "_cause"}, c, exp_cause);
  endtask

  initial begin
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset_pc_write", int'(pc_write), 1);
    check("reset_bubble", int'(idex_bubble), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // ALU -> ALU: 0, ALU -> branch: 1 (early)
    issue_instr(0, 0, 0, 0, 0, 5, 1, 1, "alu_w_x5", 0, 0);
    issue_instr(5, 1, 1, 1, 0, 6, 1, 1, "alu_alu", 0, 0);
    issue_instr(0, 0, 0, 0, 0, 5, 1, 1, "alu_w_x5b", 0, 0);
    issue_instr(5, 1, 6, 1, 1, 0, 0, 1, "alu_beq", 1, 2);
    // load -> ALU: 1 RAW, load -> jalr: 2 early
    issue_instr(0, 0, 0, 0, 0, 7, 1, 2, "ld_x7", 0, 0);
    issue_instr(7, 1, 0, 0, 0, 8, 1, 1, "ld_alu", 1, 1);
    issue_instr(0, 0, 0, 0, 0, 7, 1, 2, "ld_x7b", 0, 0);
    issue_instr(7, 1, 0, 0, 1, 1, 1, 1, "ld_jalr", 2, 2);
    // MUL x9 lat 5 then ALU write x9: 4 WAW cycles, leaving cnt[x9]=1
    issue_instr(0, 0, 0, 0, 0, 9, 1, 5, "mul_x9", 0, 0);
    issue_instr(0, 0, 0, 0, 0, 9, 1, 1, "waw_x9", 4, 3);
    issue_instr(9, 1, 0, 0, 1, 0, 0, 1, "x9_after_waw", 1, 2);
    // load x3 then hold 3 cycles with a dependent in ID
    issue_instr(0, 0, 0, 0, 0, 3, 1, 2, "ld_x3", 0, 0);
    set_instr(3, 1, 0, 0, 0, 10, 1, 1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_pc_write", int'(pc_write), 0);
      check("hold_bubble", int'(idex_bubble), 0);
      check("hold_cause", int'(stall_cause), 0);
      next_cycle();
    end
    issue_instr(3, 1, 0, 0, 0, 10, 1, 1, "after_hold", 1, 1);
    // x0 never pending
    issue_instr(0, 0, 0, 0, 0, 0, 1, 5, "w_x0", 0, 0);
    issue_instr(0, 1, 0, 1, 1, 11, 1, 1, "rd_x0", 0, 0);
    // flush with a pending hazard
    issue_instr(0, 0, 0, 0, 0, 12, 1, 2, "ld_x12", 0, 0);
    set_instr(12, 1, 0, 0, 1, 13, 1, 1);
    id_flush = 1'b1;
    @(negedge clk);
    check("flush_bubble", int'(idex_bubble), 1);
    check("flush_pc_write", int'(pc_write), 1);
    check("flush_cause", int'(stall_cause), 0);
    next_cycle();
    idle();
    next_cycle();
    // id_lat=0 behaves as 1
    issue_instr(0, 0, 0, 0, 0, 6, 1, 0, "lat0_w", 0, 0);
    issue_instr(6, 1, 0, 0, 1, 0, 0, 1, "lat0_rd", 1, 2);
    // reset mid-stall with cnt[x4]=3
    issue_instr(0, 0, 0, 0, 0, 4, 1, 3, "mul_x4", 0, 0);
    set_instr(4, 1, 0, 0, 0, 14, 1, 1);
    @(negedge clk);
    check("pre_reset_stall", int'(idex_bubble), 1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    issue_instr(4, 1, 0, 0, 1, 14, 1, 1, "post_reset_x4", 0, 0);
`ifdef HSU_PERF_EN
    @(negedge clk);
    check("perf_after_reset", int'(perf_raw + perf_early + perf_waw), 0);
`endif

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_early    = ($urandom_range(0, 3) == 0);
      id_rd       = 5'($urandom_range(0, 7));
      id_regwr    = ($urandom_range(0, 3) != 0);
      id_lat      = 3'($urandom_range(0, 7));
      id_flush    = ($urandom_range(0, 15) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      next_cycle();
    end
    rst_n = 1'b1;
    idle();
    next_cycle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
